// File: rtl/rr_request_encoder.sv
// rr_request_encoder
//   Collects up to 2**N single-bit requests into a sticky pending vector and
//   emits one N-bit binary code per request. It picks the next code by
//   round-robin priority and presents it on a valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   en         capture enable for req_i
//   req_i      request lines, bit i requests code i
//   code_o     registered index of the granted request
//   valid_o    code_o holds a granted request
//   ready_i    consumer accepts code_o when valid_o is high
//   pending_o  registered pending vector (excludes the code being held)
//   busy_o     valid_o | (|pending_o)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no code presented; load one as soon as anything is pending
// HOLD  | code_o valid; hold it until accepted, then reload or go idle

module rr_request_encoder #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2**N-1:0]   req_i,
  output logic [N-1:0]      code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [2**N-1:0]   pending_o,
  output logic              busy_o
);

  localparam int W = 2**N;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    pending, pending_nxt;
  logic [N-1:0]    ptr, ptr_nxt;
  logic [N-1:0]    code_nxt;
  logic            valid_nxt;

  logic [N-1:0]    base;
  logic [N-1:0]    sel;
  logic            found;
  logic            load;
  logic [W-1:0]    clr;
  logic [N-1:0]    idx;

  // After a handshake the search must start just past the accepted code,
  // even though ptr itself only catches up on this same edge.
  always_comb begin
    base = ptr;
    if (state == HOLD) base = code_o + N'(1);
  end

  // Round-robin search of the registered pending vector, wrapping at W-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < W; i++) begin
      idx = base + N'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_o;
    valid_nxt = valid_o;
    ptr_nxt   = ptr;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          load      = 1'b1;
          code_nxt  = sel;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          ptr_nxt = code_o + N'(1);
          if (found) begin
            load     = 1'b1;
            code_nxt = sel;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    clr = '0;
    if (load) clr[sel] = 1'b1;
    // Set is OR'd after the clear so a re-request of the loaded bit survives.
    pending_nxt = (pending & ~clr) | (en ? req_i : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ptr     <= '0;
      code_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      ptr     <= ptr_nxt;
      code_o  <= code_nxt;
      valid_o <= valid_nxt;
    end
  end

  assign pending_o = pending;
  assign busy_o    = valid_o | (|pending);

endmodule

// File: tb/tb_rr_request_encoder.sv
module tb_rr_request_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req_i;
  logic        ready_i;
  logic [3:0]  code_o;
  logic        valid_o;
  logic [15:0] pending_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  rr_request_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_i     (req_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic [15:0] p);
    chk({tag, "_valid"},   {31'd0, valid_o}, {31'd0, v});
    chk({tag, "_code"},    {28'd0, code_o},  {28'd0, c});
    chk({tag, "_pending"}, {16'd0, pending_o}, {16'd0, p});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_i = '0; ready_i = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 4'd0, 16'h0000);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;

    // single request, code 5, then accept (ptr -> 6)
    en = 1'b1; req_i = 16'h0020;
    tick(); chk_out("single_cap", 1'b0, 4'd0, 16'h0020);
    req_i = '0;
    tick(); chk_out("single_load", 1'b1, 4'd5, 16'h0000);
    chk("single_busy", {31'd0, busy_o}, 32'd1);
    ready_i = 1'b1;
    tick(); chk_out("single_acc", 1'b0, 4'd5, 16'h0000);
    chk("single_idle_busy", {31'd0, busy_o}, 32'd0);
    ready_i = 1'b0;

    // ptr=6: bits 4 and 7 pending -> 7 wins, then 4
    req_i = 16'h0090;
    tick(); chk_out("ptr6_cap", 1'b0, 4'd5, 16'h0090);
    req_i = '0;
    tick(); chk_out("ptr6_first", 1'b1, 4'd7, 16'h0010);
    ready_i = 1'b1;
    tick(); chk_out("ptr6_second", 1'b1, 4'd4, 16'h0000);
    tick(); chk_out("ptr6_done", 1'b0, 4'd4, 16'h0000);
    ready_i = 1'b0;

    // asynchronous reset mid-cycle with a held code and pending requests
    req_i = 16'h0400;
    tick(); req_i = '0;
    tick(); chk_out("pre_rst_load", 1'b1, 4'd10, 16'h0000);
    req_i = 16'h0003;
    tick(); chk_out("pre_rst_hold", 1'b1, 4'd10, 16'h0003);
    req_i = '0;
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 4'd0, 16'h0000);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("idle_busy", {31'd0, busy_o}, 32'd0);
    end

    // back-to-back round robin from ptr=0
    req_i = 16'h8101;
    tick(); chk_out("rr_cap", 1'b0, 4'd0, 16'h8101);
    req_i = '0; ready_i = 1'b1;
    tick(); chk_out("rr_g0", 1'b1, 4'd0, 16'h8100);
    tick(); chk_out("rr_g8", 1'b1, 4'd8, 16'h8000);
    tick(); chk_out("rr_g15", 1'b1, 4'd15, 16'h0000);
    tick(); chk_out("rr_done", 1'b0, 4'd15, 16'h0000);

    // fairness: ptr wrapped to 0, bits 0/1 held continuously
    req_i = 16'h0003;
    tick(); chk_out("fair_cap", 1'b0, 4'd15, 16'h0003);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("fair_alt", 1'b1, (i % 2 == 0) ? 4'd0 : 4'd1, 16'h0003);
    end
    req_i = '0;
    tick(); chk_out("fair_drain0", 1'b1, 4'd0, 16'h0002);
    tick(); chk_out("fair_drain1", 1'b1, 4'd1, 16'h0000);
    tick(); chk_out("fair_done", 1'b0, 4'd1, 16'h0000);
    ready_i = 1'b0;

    // backpressure and merge on index 3
    req_i = 16'h0008;
    tick(); chk_out("bp_cap", 1'b0, 4'd1, 16'h0008);
    req_i = '0;
    tick(); chk_out("bp_load", 1'b1, 4'd3, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out("bp_stall", 1'b1, 4'd3, 16'h0000);
    end
    req_i = 16'h0008;
    tick(); chk_out("bp_repulse", 1'b1, 4'd3, 16'h0008);
    req_i = '0; ready_i = 1'b1;
    tick(); chk_out("bp_regrant", 1'b1, 4'd3, 16'h0000);
    tick(); chk_out("bp_done", 1'b0, 4'd3, 16'h0000);
    ready_i = 1'b0;

    // enable gating
    en = 1'b0; req_i = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("en_gate", 1'b0, 4'd3, 16'h0000);
    end
    req_i = '0; en = 1'b1;

    // set-wins: bit 2 re-requested on the edge it is loaded
    req_i = 16'h0004;
    tick(); chk_out("sw_cap", 1'b0, 4'd3, 16'h0004);
    tick(); chk_out("sw_load", 1'b1, 4'd2, 16'h0004);
    req_i = '0; ready_i = 1'b1;
    tick(); chk_out("sw_regrant", 1'b1, 4'd2, 16'h0000);
    tick(); chk_out("sw_done", 1'b0, 4'd2, 16'h0000);
    ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_request_encoder.md
Name: rr_request_encoder

Overview:
- Inverse companion of the N-bit enabled one-hot decoder: collects up to 2**N single-bit requests and emits one N-bit binary code per request.
- Captures requests into a sticky pending vector and selects one pending bit per grant by round-robin priority.
- Presents the code on a valid/ready output handshake.
- Used where many one-hot sources must share a single encoded index bus, for example register-file or memory-bank write-back select.

Parameters:
- N, 4, code width; the request vector is 2**N bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; `req_i` is sampled only when en=1.
- req_i  input  2**N  request lines, one per source; bit i requests code i.
- code_o  output  N  encoded index of the granted request; registered.
- valid_o  output  1  `code_o` holds a granted request; registered.
- ready_i  input  1  consumer accepts `code_o` when valid_o=1 and ready_i=1.
- pending_o  output  2**N  registered pending vector, excluding the granted request held on `code_o`.
- busy_o  output  1  OR of valid_o and pending_o.

Behaviour:
- Reset (asynchronous, active-high):
  - pending = 0, code_o = 0, valid_o = 0.
  - Round-robin pointer ptr = 0; state = IDLE.
  - Outputs reflect these values while rst=1.
- Capture, every edge:
  - `pending_next = (pending & ~clr) | (en ? req_i : 0)`.
  - clr is the one-hot of the index loaded into `code_o` this edge.
  - Set has priority over clear: a re-request of the bit being loaded keeps that bit pending.
  - A request for a bit already pending merges; it is not counted twice.
  - `req_i` while en=0 is discarded. Already-pending bits are still served.
- Selection:
  - Choose the first set bit of the registered pending vector searching upward from ptr, wrapping from 2**N-1 to 0.
  - Requests sampled this edge are not visible to the search until the next edge.
- States:
  - IDLE (valid_o=0):
    - pending != 0 -> load code_o = selected index, clear that bit, valid_o <= 1, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD (valid_o=1):
    - `code_o` and `valid_o` stay stable while ready_i=0.
    - On handshake (valid_o & ready_i):
      - ptr <= code_o + 1, mod 2**N.
      - If pending != 0, load the next selection, searched from code_o+1, and stay in HOLD with valid_o=1. This gives back-to-back grants with no bubble.
      - Otherwise valid_o <= 0 and go to IDLE. `code_o` keeps its last value.
    - ready_i is ignored while valid_o=0.
- Latency:
  - Request sampled at edge k into an empty IDLE block -> valid_o=1 after edge k+1.
  - Sustained throughput with ready_i=1: one code per cycle.
- Fairness: a continuously pending index waits at most 2**N-1 grants.
- Reset mid-operation:
  - All pending requests and any unaccepted code are lost.
  - The block returns to IDLE with ptr=0; a handshake in flight is void.
- N=1 is legal (2 request lines, 1-bit code).

Test Plan:
1. Reset and idle: assert rst asynchronously mid-cycle -> valid_o=0, code_o=0, pending_o=0 immediately; en=1, req_i=0 for 10 cycles -> busy_o stays 0.
2. Single request, N=4: pulse req_i=16'h0020 with en=1 at edge k -> pending_o=16'h0020 after edge k; valid_o=1, code_o=5, pending_o=0 after edge k+1; ready_i=1 -> valid_o=0 after the next edge, ptr=6.
3. Back-to-back round-robin with ptr=0: pulse req_i=16'h8101, ready_i held 1 -> code_o = 0, 8, 15 on consecutive cycles with valid_o high throughout; then valid_o drops and ptr wraps to 0.
4. Fairness: hold req_i=16'h0003 continuously, ready_i=1 -> code_o alternates 0,1,0,1; never two consecutive grants of the same index.
5. Backpressure and merge: request index 3, hold ready_i=0 for 5 cycles -> code_o=3 stable and valid_o=1; re-pulse bit 3 -> pending_o=16'h0008; on accept the next code is 3.
6. Enable gating and set-wins:
   - en=0 with req_i=16'hFFFF -> nothing captured, pending_o=0, valid_o=0.
   - en=1, re-request the bit on the exact edge it is loaded -> that bit stays pending and is granted again.
